// File: rtl/pc_ir_unit_if.sv
// Bus between the multicycle control FSM / datapath and the PC/IR unit.
// The master side drives the FSM strobes, ALU flags and memory read data;
// the slave side (pc_ir_unit) returns the address, PC state and registers.
interface pc_ir_unit_if;
  logic        PCUpdate;
  logic        Branch;
  logic        IRWrite;
  logic        AdrSrc;
  logic        Zero;
  logic [31:0] Result;
  logic [31:0] ReadData;
  logic [31:0] Adr;
  logic        PCWrite;
  logic [31:0] PC;
  logic [31:0] OldPC;
  logic [31:0] Instr;
  logic [6:0]  op;
  logic [31:0] Data;
  logic        instr_valid;
  logic        misalign;
  logic [31:0] instret;

  modport master (
    output PCUpdate, Branch, IRWrite, AdrSrc, Zero, Result, ReadData,
    input  Adr, PCWrite, PC, OldPC, Instr, op, Data, instr_valid,
           misalign, instret
  );

  modport slave (
    input  PCUpdate, Branch, IRWrite, AdrSrc, Zero, Result, ReadData,
    output Adr, PCWrite, PC, OldPC, Instr, op, Data, instr_valid,
           misalign, instret
  );
endinterface

// File: rtl/pc_ir_unit.sv
// Architectural-state front end of the multicycle RV32I core: PC, OldPC,
// instruction register, memory data register, PC write-enable formation,
// unified memory address mux, sticky misaligned-target flag and a
// fetched-instruction counter.
module pc_ir_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  pc_ir_unit_if.slave bus
);

  logic        pc_write_s;
  logic [31:0] adr_s;
  logic        target_misaligned_s;

  logic [31:0] pc_r;
  logic [31:0] old_pc_r;
  logic [31:0] instr_r;
  logic [31:0] data_r;
  logic        instr_valid_r;
  logic        misalign_r;
  logic [31:0] instret_r;

  // PC write enable, memory address select and target alignment test
  always_comb begin
    pc_write_s          = 1'b0;
    adr_s               = pc_r;
    target_misaligned_s = 1'b0;
    pc_write_s          = bus.PCUpdate | (bus.Branch & bus.Zero);
    if (bus.AdrSrc) begin
      adr_s = bus.Result;
    end else begin
      adr_s = pc_r;
    end
    target_misaligned_s = (bus.Result[1:0] != 2'b00);
  end

  // PC load with low bits forced to zero; misalign is sticky until reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_r       <= RESET_PC;
      misalign_r <= 1'b0;
    end else if (pc_write_s) begin
      pc_r <= {bus.Result[31:2], 2'b00};
      if (target_misaligned_s) begin
        misalign_r <= 1'b1;
      end else begin
        misalign_r <= misalign_r;
      end
    end else begin
      pc_r       <= pc_r;
      misalign_r <= misalign_r;
    end
  end

  // Fetch capture: IR, OldPC from the pre-edge PC, valid flag and counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr_r       <= NOP_INSTR;
      old_pc_r      <= RESET_PC;
      instr_valid_r <= 1'b0;
      instret_r     <= 32'h0000_0000;
    end else if (bus.IRWrite) begin
      instr_r       <= bus.ReadData;
      old_pc_r      <= pc_r;
      instr_valid_r <= 1'b1;
      instret_r     <= instret_r + 32'h0000_0001;
    end else begin
      instr_r       <= instr_r;
      old_pc_r      <= old_pc_r;
      instr_valid_r <= instr_valid_r;
      instret_r     <= instret_r;
    end
  end

  // Memory data register samples read data every cycle for load writeback
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_r <= 32'h0000_0000;
    end else begin
      data_r <= bus.ReadData;
    end
  end

  assign bus.PCWrite     = pc_write_s;
  assign bus.Adr         = adr_s;
  assign bus.PC          = pc_r;
  assign bus.OldPC       = old_pc_r;
  assign bus.Instr       = instr_r;
  assign bus.op          = instr_r[6:0];
  assign bus.Data        = data_r;
  assign bus.instr_valid = instr_valid_r;
  assign bus.misalign    = misalign_r;
  assign bus.instret     = instret_r;

endmodule

// File: tb/tb_pc_ir_unit.sv
// Self-checking bench for pc_ir_unit: directed scenarios followed by random
// strobes, compared against a per-cycle architectural model of PC/IR state.
module tb_pc_ir_unit;
  logic clk = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  pc_ir_unit_if bus ();

  pc_ir_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // architectural model state
  logic [31:0] m_pc, m_oldpc, m_instr, m_data, m_instret;
  logic        m_iv, m_mis;
  logic [31:0] mem [0:255];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc      = 32'h0;
    m_oldpc   = 32'h0;
    m_instr   = 32'h0000_0013;
    m_data    = 32'h0;
    m_iv      = 1'b0;
    m_mis     = 1'b0;
    m_instret = 32'h0;
  endtask

  task automatic check_regs();
    check("PC", bus.PC, m_pc);
    check("OldPC", bus.OldPC, m_oldpc);
    check("Instr", bus.Instr, m_instr);
    check("Data", bus.Data, m_data);
    check("instr_valid", {31'b0, bus.instr_valid}, {31'b0, m_iv});
    check("misalign", {31'b0, bus.misalign}, {31'b0, m_mis});
    check("instret", bus.instret, m_instret);
  endtask

  // Called just after a falling edge; applies inputs, checks combinational
  // outputs, advances one rising edge and checks the registered state.
  task automatic step(input logic pcu, input logic br, input logic irw,
                      input logic asrc, input logic z,
                      input logic [31:0] res, input logic [31:0] rd);
    logic        exp_pcw;
    logic [31:0] exp_adr;
    bus.PCUpdate = pcu;
    bus.Branch   = br;
    bus.IRWrite  = irw;
    bus.AdrSrc   = asrc;
    bus.Zero     = z;
    bus.Result   = res;
    bus.ReadData = rd;
    exp_pcw = pcu || (br && z);
    exp_adr = asrc ? res : m_pc;
    #1;
    check("PCWrite", {31'b0, bus.PCWrite}, {31'b0, exp_pcw});
    check("Adr", bus.Adr, exp_adr);
    check("op", {25'b0, bus.op}, {25'b0, m_instr[6:0]});
    @(posedge clk);
    if (irw) begin
      m_oldpc   = m_pc;
      m_instr   = rd;
      m_iv      = 1'b1;
      m_instret = m_instret + 32'd1;
    end
    if (exp_pcw) begin
      m_pc = (res / 32'd4) * 32'd4;
      if ((res % 32'd4) != 32'd0) m_mis = 1'b1;
    end
    m_data = rd;
    #1;
    check_regs();
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] res, adr, rd;
    logic        pcu, br, irw, asrc, z;

    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    bus.PCUpdate = 1'b0; bus.Branch = 1'b0; bus.IRWrite = 1'b0;
    bus.AdrSrc = 1'b0; bus.Zero = 1'b0; bus.Result = 32'h0; bus.ReadData = 32'h0;
    model_reset();

    // reset held with random inputs: no strobe honoured
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.PCUpdate = 1'b1; bus.Branch = 1'($urandom); bus.IRWrite = 1'b1;
      bus.AdrSrc = 1'($urandom); bus.Zero = 1'($urandom);
      bus.Result = $urandom; bus.ReadData = $urandom;
      @(posedge clk);
      #1;
      check_regs();
    end
    @(negedge clk);
    reset = 1'b1;

    // Adr follows PC=0 after reset
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0555, 32'h1234_5678);

    // fetch scenario
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0100, 32'h0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0104, 32'h0050_0093);
    check("fetch.Instr", bus.Instr, 32'h0050_0093);
    check("fetch.OldPC", bus.OldPC, 32'h0000_0100);
    check("fetch.PC", bus.PC, 32'h0000_0104);
    check("fetch.op", {25'b0, bus.op}, 32'h0000_0013);
    check("fetch.instret", bus.instret, 32'd1);
    check("fetch.valid", {31'b0, bus.instr_valid}, 32'd1);

    // branch not taken / taken
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0201, 32'h0);
    check("bnt.PC", bus.PC, 32'h0000_0104);
    check("bnt.misalign", {31'b0, bus.misalign}, 32'd0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0200, 32'h0);
    check("bt.PC", bus.PC, 32'h0000_0200);

    // misaligned target, then sticky through aligned loads
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0306, 32'h0);
    check("mis.PC", bus.PC, 32'h0000_0304);
    check("mis.flag", {31'b0, bus.misalign}, 32'd1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0400, 32'h0);
    check("mis.sticky", {31'b0, bus.misalign}, 32'd1);

    // load path
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0040, 32'hDEAD_BEEF);
    check("load.Data", bus.Data, 32'hDEAD_BEEF);
    check("load.Instr", bus.Instr, 32'h0050_0093);

    // instret wrap
    force dut.instret_r = 32'hFFFF_FFFF;
    #1;
    release dut.instret_r;
    m_instret = 32'hFFFF_FFFF;
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0000_0033);
    check("wrap.instret", bus.instret, 32'd0);

    // asynchronous reset mid-cycle
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_regs();
    check("async.misalign", {31'b0, bus.misalign}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // random traffic with occasional async reset
    for (int n = 0; n < 300; n++) begin
      pcu  = ($urandom_range(0, 3) == 0);
      br   = ($urandom_range(0, 3) == 0);
      irw  = ($urandom_range(0, 2) == 0);
      asrc = 1'($urandom);
      z    = 1'($urandom);
      res  = ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & 32'h0000_03FC);
      adr  = asrc ? res : m_pc;
      rd   = mem[(adr / 32'd4) % 32'd256];
      step(pcu, br, irw, asrc, z, res, rd);
      if ($urandom_range(0, 39) == 0) begin
        #3;
        reset = 1'b0;
        #1;
        model_reset();
        check_regs();
        @(negedge clk);
        reset = 1'b1;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pc_ir_unit.md
# pc_ir_unit

Architectural-state front end of the multicycle RV32I core, directly downstream of the multicycle control FSM. It holds PC, OldPC, the instruction register (IR) and the memory data register. It forms the PC write enable from the FSM's PCUpdate/Branch strobes and the ALU Zero flag, and drives the unified memory address mux. It feeds the opcode field back to the FSM and keeps a sticky misaligned-target flag and a retired-instruction counter.

## Interface
- RESET_PC, 32'h0000_0000, PC and OldPC value after reset
- NOP_INSTR, 32'h0000_0013, IR value after reset (addi x0,x0,0)
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- PCUpdate  in  1  unconditional PC load strobe from FSM
- Branch  in  1  conditional PC load strobe from FSM (BEQ state)
- IRWrite  in  1  IR/OldPC load strobe from FSM (fetch state)
- AdrSrc  in  1  address select: 0 = PC, 1 = Result
- Zero  in  1  ALU zero flag
- Result  in  32  result bus (PC target / data address)
- ReadData  in  32  unified memory read data (combinational read)
- Adr  out  32  memory address
- PCWrite  out  1  effective PC write enable
- PC  out  32  program counter
- OldPC  out  32  PC of instruction currently in IR
- Instr  out  32  instruction register
- op  out  7  Instr[6:0], to FSM
- Data  out  32  memory data register
- instr_valid  out  1  IR holds a fetched instruction
- misalign  out  1  sticky: a PC load target had Result[1:0] != 0
- instret  out  32  retired/fetched instruction count

## Operation
- PCWrite = PCUpdate | (Branch & Zero); combinational.
- Adr = AdrSrc ? Result : PC; combinational. op = Instr[6:0].
- PCWrite=1 at an edge: PC <= {Result[31:2], 2'b00}. If Result[1:0] != 0, misalign <= 1. The PC is still loaded, with the low bits forced to 0.
- misalign is sticky and clears only on reset.
- IRWrite=1 at an edge:
  - Instr <= ReadData.
  - OldPC <= PC, using the pre-edge PC, even when PCWrite is asserted in the same cycle, which is the fetch case.
  - instr_valid <= 1.
  - instret <= instret + 1, mod 2^32, wrapping from 32'hFFFF_FFFF to 0.
- Data <= ReadData on every edge, unconditionally.
- IRWrite with AdrSrc=1 is legal: IR captures whatever ReadData shows. No checking is done.
- Branch=1 with Zero=0 leaves PC unchanged and misalign unchanged, regardless of Result.
- Reset asserted (reset=0), asynchronously:
  - PC = OldPC = RESET_PC
  - Instr = NOP_INSTR
  - Data = 0
  - instr_valid = 0
  - misalign = 0
  - instret = 0
- Reset mid-instruction abandons all state. The first edge after release behaves as a normal cycle.

## Timing
- All registered outputs update on the rising clk edge following the strobe (1-cycle latency): PC, OldPC, Instr, Data, instr_valid, misalign, instret.
- Adr, PCWrite and op have zero latency from their sources.
- Reset release is synchronous to clk use only. No strobe is honored while reset=0.
- Fetch cycle (IRWrite=1, PCUpdate=1, AdrSrc=0, Result=PC+4): after the edge, Instr = mem[old PC], OldPC = old PC, PC = old PC + 4.
- Data captures the value present during the cycle. It is valid in the following state, for use by a load's writeback.
- No combinational path from ReadData to any output except through registers.

## Test plan
- Reset: hold reset=0 with random inputs, then release. Required: PC=0, OldPC=0, Instr=32'h13, instr_valid=0, misalign=0, instret=0, Adr=0 with AdrSrc=0.
- Fetch: PC=0x100, ReadData=0x00500093, IRWrite=PCUpdate=1, Result=0x104, then one edge. Required: Instr=0x00500093, OldPC=0x100, PC=0x104, op=7'h13, instret=1, instr_valid=1.
- Branch: Branch=1, Result=0x200.
  - Zero=0: PC unchanged, PCWrite=0.
  - Zero=1: PC=0x200, PCWrite=1 in that cycle.
- Misalign: PCUpdate=1, Result=0x00000306. Required: PC=0x304, misalign=1. Further aligned loads leave misalign=1 until reset.
- Load path: AdrSrc=1, Result=0x40. Required: Adr=0x40 and, after one edge with ReadData=0xDEADBEEF, Data=0xDEADBEEF, while Instr is unchanged.
- Wrap and reset mid-op: preload instret near wrap (force, or 2^32 fetches in a formal run), one more IRWrite gives instret=0. Asserting reset=0 asynchronously mid-cycle clears all registers immediately, without waiting for clk.
